// File: rtl/aes_inv_cipher_if.sv
// aes_inv_cipher_if
//   Bundles the request/result signals of the AES-128 inverse cipher.
//   master : the requester. Drives load/key/cyphertext and receives plaintext/done/busy.
//   slave  : the cipher core. Receives the request and drives the registered results.
interface aes_inv_cipher_if;
    logic         load;
    logic [127:0] key;
    logic [127:0] cyphertext;
    logic [127:0] plaintext;
    logic         done;
    logic         busy;

    modport master (output load, key, cyphertext, input plaintext, done, busy);
    modport slave  (input load, key, cyphertext, output plaintext, done, busy);
endinterface

// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher
//   Iterative AES-128 decryptor that processes one round per clock.
//   The round keys are not stored. The core runs the key schedule forward to round key 10,
//   then walks it backwards one round key per clock while it decrypts.
//   Ports:
//     clk     : rising-edge clock
//     reset_n : asynchronous active-low reset
//     bus     : slave modport of aes_inv_cipher_if
//       load         start request. Honoured only in IDLE or DONE.
//       key          cipher key. Byte 0 is [127:120].
//       cyphertext   input block. Byte 0 is [127:120].
//       plaintext    registered result. Keeps its value until the next result is ready.
//       done         level signal. High while plaintext holds a completed result.
//       busy         high from the accepting edge until done rises
//   Latency: load accepted at E0 -> done/plaintext valid after E21.

package aes_inv_cipher_pkg;
    // Multiply by x in GF(2^8), reducing modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (aa & {8{b[i]}});
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254. Zero maps to zero, as the S-box definition expects.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_affine(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte n sits at [127-8n -: 8]. Row r, column c is byte 4c+r.
    // Row r is rotated right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction
endpackage

// Forward S-box. It is computed rather than tabulated.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    import aes_inv_cipher_pkg::*;
    assign out_byte = sbox_affine(gf_inv(in_byte));
endmodule

// Inverse S-box. Undo the affine map, then invert.
module aes_inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    import aes_inv_cipher_pkg::*;
    assign out_byte = gf_inv(inv_sbox_affine(in_byte));
endmodule

module add_round_key (
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic [127:0] state_out
);
    assign state_out = state_in ^ round_key;
endmodule

module aes_inv_cipher (
    input  logic              clk,
    input  logic              reset_n,
    aes_inv_cipher_if.slave   bus
);
    import aes_inv_cipher_pkg::*;

    typedef enum logic [2:0] {S_IDLE, S_KEYFWD, S_INIT, S_ROUND, S_FINAL, S_DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] pt_q, pt_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [127:0] isr_s, isb_s, ark_in_s, ark_s;
    logic [31:0]  w0_s, w1_s, w2_s, w3_s, p3_s, sb_in_s, rot_s, sw_s, lead_s;
    logic [127:0] rk_fwd_s, rk_prev_s;
    logic [3:0]   rc_idx_s;

    assign isr_s = inv_shift_rows(blk_q);

    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_isb
            aes_inv_sbox u_isb (.in_byte(isr_s[8*g +: 8]), .out_byte(isb_s[8*g +: 8]));
        end
        for (g = 0; g < 4; g++) begin : g_sb
            aes_sbox u_sb (.in_byte(rot_s[8*g +: 8]), .out_byte(sw_s[8*g +: 8]));
        end
    endgenerate

    // INIT whitens the raw state. Every other state adds the key after InvSubBytes.
    always_comb begin
        if (fsm_q == S_INIT) begin
            ark_in_s = blk_q;
            rc_idx_s = 4'd10;
        end else begin
            ark_in_s = isb_s;
            rc_idx_s = cnt_q;
        end
    end

    add_round_key u_ark (.state_in(ark_in_s), .round_key(rk_q), .state_out(ark_s));

    // The forward step rotates w3. The inverse step rotates the recovered w3 of the previous key, which is w3^w2.
    // Both steps share the four S-boxes.
    assign {w0_s, w1_s, w2_s, w3_s} = rk_q;
    assign p3_s      = w3_s ^ w2_s;
    assign sb_in_s   = (fsm_q == S_KEYFWD) ? w3_s : p3_s;
    assign rot_s     = {sb_in_s[23:0], sb_in_s[31:24]};
    assign lead_s    = w0_s ^ sw_s ^ {rcon(rc_idx_s), 24'h0};
    assign rk_fwd_s  = {lead_s, lead_s ^ w1_s, lead_s ^ w1_s ^ w2_s, lead_s ^ w1_s ^ w2_s ^ w3_s};
    assign rk_prev_s = {lead_s, w1_s ^ w0_s, w2_s ^ w1_s, p3_s};

    // Next-state and datapath control for the FSM.
    always_comb begin
        fsm_d  = fsm_q;
        blk_d  = blk_q;
        rk_d   = rk_q;
        pt_d   = pt_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = done_q;
        case (fsm_q)
            S_IDLE, S_DONE: begin
                if (bus.load) begin
                    rk_d   = bus.key;
                    blk_d  = bus.cyphertext;
                    cnt_d  = 4'd1;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    fsm_d  = S_KEYFWD;
                end else begin
                    fsm_d = fsm_q;
                end
            end
            S_KEYFWD: begin
                rk_d  = rk_fwd_s;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd10) begin
                    fsm_d = S_INIT;
                end else begin
                    fsm_d = S_KEYFWD;
                end
            end
            S_INIT: begin
                blk_d = ark_s;
                rk_d  = rk_prev_s;
                cnt_d = 4'd9;
                fsm_d = S_ROUND;
            end
            S_ROUND: begin
                blk_d = inv_mix_columns(ark_s);
                rk_d  = rk_prev_s;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    fsm_d = S_FINAL;
                end else begin
                    fsm_d = S_ROUND;
                end
            end
            S_FINAL: begin
                pt_d   = ark_s;
                done_d = 1'b1;
                busy_d = 1'b0;
                fsm_d  = S_DONE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q  <= S_IDLE;
            blk_q  <= 128'h0;
            rk_q   <= 128'h0;
            pt_q   <= 128'h0;
            cnt_q  <= 4'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            blk_q  <= blk_d;
            rk_q   <= rk_d;
            pt_q   <= pt_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.plaintext = pt_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_aes_inv_cipher.sv
// tb_aes_inv_cipher
//   Directed bench for aes_inv_cipher. Known-answer results are queued when a load is driven.
//   They are popped and compared when done rises.
module tb_aes_inv_cipher;
    localparam logic [127:0] KEY_B  = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] CT_B   = 128'h3925841D02DC09FBDC118597196A0B32;
    localparam logic [127:0] PT_B   = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] INIT_B = 128'hE9317DB5CB322C723D2E895FAF090794;
    localparam logic [127:0] KEY_C  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] CT_C   = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899AABBCCDDEEFF;

    logic clk = 1'b0;
    logic reset_n;
    aes_inv_cipher_if bus ();

    aes_inv_cipher dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [127:0] sb_q [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [127:0] pt, input logic dn, input logic bz);
        chk({tag, "_plaintext"}, bus.plaintext, pt);
        chk({tag, "_done"}, {127'h0, bus.done}, {127'h0, dn});
        chk({tag, "_busy"}, {127'h0, bus.busy}, {127'h0, bz});
    endtask

    // Drive one load. Then scramble the inputs to show they are ignored after acceptance.
    task automatic start(input string tag, input logic [127:0] k, input logic [127:0] ct,
                         input logic [127:0] exp, input logic [127:0] hold);
        bus.load       = 1'b1;
        bus.key        = k;
        bus.cyphertext = ct;
        sb_q.push_back(exp);
        tick;
        bus.load       = 1'b0;
        bus.key        = {$urandom, $urandom, $urandom, $urandom};
        bus.cyphertext = {$urandom, $urandom, $urandom, $urandom};
        chk_outs({tag, "_accept"}, hold, 1'b0, 1'b1);
    endtask

    task automatic wait_done(input string tag, input bit chk_init, input int pulse_at,
                             input logic [127:0] hold);
        int lat;
        logic [127:0] e;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick;
            if (chk_init && i == 11) chk({tag, "_init_state"}, dut.blk_q, INIT_B);
            if (i == 20) chk({tag, "_hold_e20"}, bus.plaintext, hold);
            if (pulse_at != 0 && i == pulse_at) begin
                bus.load       = 1'b1;
                bus.key        = KEY_C;
                bus.cyphertext = CT_C;
            end
            if (pulse_at != 0 && i == pulse_at + 1) bus.load = 1'b0;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus.load = 1'b0;
        chk({tag, "_latency"}, {96'h0, 32'(lat)}, {96'h0, 32'd21});
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else e = {128{1'bx}};
        chk_outs({tag, "_result"}, e, 1'b1, 1'b0);
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.load       = 1'b0;
        bus.key        = 128'h0;
        bus.cyphertext = 128'h0;
        #12;
        chk_outs("reset", 128'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        tick;

        // FIPS-197 App. B, including the state after the initial AddRoundKey.
        start("appb", KEY_B, CT_B, PT_B, 128'h0);
        wait_done("appb", 1'b1, 0, 128'h0);
        repeat (3) tick;
        chk_outs("appb_level", PT_B, 1'b1, 1'b0);

        // Back-to-back: load in DONE. done drops and the old plaintext holds.
        start("b2b_c1", KEY_C, CT_C, PT_C, PT_B);
        wait_done("b2b_c1", 1'b0, 0, PT_B);

        // A load while busy is dropped and is not queued.
        start("busyload", KEY_B, CT_B, PT_B, PT_C);
        wait_done("busyload", 1'b0, 5, PT_C);
        repeat (25) tick;
        chk_outs("busyload_nosecond", PT_B, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle from DONE.
        #3 reset_n = 1'b0;
        #1 chk_outs("async_reset_done", 128'h0, 1'b0, 1'b0);
        #1 reset_n = 1'b1;
        tick;

        // Reset in the middle of a run, then a fresh C.1 decrypt.
        start("midrun", KEY_B, CT_B, PT_B, 128'h0);
        repeat (11) tick;
        #3 reset_n = 1'b0;
        #1 chk_outs("midrun_reset", 128'h0, 1'b0, 1'b0);
        sb_q.delete();
        #1 reset_n = 1'b1;
        tick;
        start("after_reset_c1", KEY_C, CT_C, PT_C, 128'h0);
        wait_done("after_reset_c1", 1'b0, 0, 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
